mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 32x64 data memory, branch resolve and writeback registers.
// Optional MEMWB_ALIGN_CHECK_EN flags misaligned accesses via a sticky align_err.
module mem_wb_stage (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ex_valid,
  input  logic        ex_isZeroBranch,
  input  logic        ex_isUnconBranch,
  input  logic        ex_memRead,
  input  logic        ex_memwrite,
  input  logic        ex_regwrite,
  input  logic        ex_mem2reg,
  input  logic [63:0] ex_shifted_pc,
  input  logic        ex_alu_zero,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_write_data,
  input  logic [4:0]  ex_write_reg,
  output logic        branch_taken,
  output logic [63:0] branch_target,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_write_reg,
  output logic [63:0] wb_write_data,
  output logic [63:0] wb_mem_data,
  output logic [63:0] wb_alu_result,
  output logic        align_err
);

  localparam int unsigned Depth = 32;

  logic [4:0]  mem_idx;
  logic [63:0] rd_word [Depth];
  logic        misalign;
  logic        mem_we;
  logic        unused_addr;

  logic        valid_q;
  logic        regwrite_q;
  logic [4:0]  write_reg_q;
  logic [63:0] mem_data_q;
  logic [63:0] alu_result_q;
  logic        mem2reg_q;

  assign mem_idx     = ex_alu_result[7:3];
  assign unused_addr = ^{ex_alu_result[63:8], ex_alu_result[2:0]};

`ifdef MEMWB_ALIGN_CHECK_EN
  logic align_q;

  assign misalign = ex_valid & (ex_memRead | ex_memwrite) & (ex_alu_result[2:0] != 3'b000);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      align_q <= 1'b0;
    end else if (misalign) begin
      align_q <= 1'b1;
    end
  end

  assign align_err = align_q;
`else
  assign misalign  = 1'b0;
  assign align_err = 1'b0;
`endif

  // Reset level is sampled here so a store landing on an edge during reset is dropped.
  assign mem_we = RESET_N & ex_valid & ex_memwrite & ~misalign;

  // Memory words carry their power-up contents and are deliberately outside the reset domain.
  for (genvar i = 0; i < Depth; i++) begin : g_mem
    logic [63:0] word_q = 64'(i);

    always_ff @(posedge CLOCK) begin
      if (mem_we && (mem_idx == 5'(i))) begin
        word_q <= ex_write_data;
      end
    end

    assign rd_word[i] = word_q;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= 5'd0;
      mem_data_q   <= 64'd0;
      alu_result_q <= 64'd0;
      mem2reg_q    <= 1'b0;
    end else begin
      valid_q      <= ex_valid;
      regwrite_q   <= ex_valid & ex_regwrite & (ex_write_reg != 5'd31) & ~misalign;
      write_reg_q  <= ex_write_reg;
      alu_result_q <= ex_alu_result;
      mem2reg_q    <= ex_mem2reg;
      if (ex_valid && ex_memRead) begin
        mem_data_q <= rd_word[mem_idx];
      end
    end
  end

  assign branch_taken  = ex_valid & ((ex_isZeroBranch & ex_alu_zero) | ex_isUnconBranch);
  assign branch_target = ex_shifted_pc;

  assign wb_valid      = valid_q;
  assign wb_regwrite   = regwrite_q;
  assign wb_write_reg  = write_reg_q;
  assign wb_mem_data   = mem_data_q;
  assign wb_alu_result = alu_result_q;
  assign wb_write_data = mem2reg_q ? mem_data_q : alu_result_q;

endmodule
